// File: rtl/apb_bus_arbiter_if.sv
// Requester and APB bus signals of the two-port APB arbiter, bundled for port hookup.
// The master modport is the arbiter side, the slave modport is the environment side.
interface apb_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_done;
    logic [DATA_WIDTH-1:0] req0_rdata;
    logic                  req0_err;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_done;
    logic [DATA_WIDTH-1:0] req1_rdata;
    logic                  req1_err;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_done, req1_rdata, req1_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_done, req0_rdata, req0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_done, req1_rdata, req1_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_bus_arbiter.sv
// Two-requester APB3 master: round-robin grant, SETUP/ACCESS sequencing,
// per-port completion pulse with read data/error, and an ACCESS wait-state timeout.
module apb_bus_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input logic               pclk,
    input logic               presetn,
    apb_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  gnt_q, gnt_d;
    logic [7:0]            wait_q, wait_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;

    logic                  g;
    logic                  cmp;
    logic                  cmp_err;
    logic [DATA_WIDTH-1:0] cmp_rdata;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        gnt_d     = gnt_q;
        wait_d    = wait_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        g         = 1'b0;
        cmp       = 1'b0;
        cmp_err   = 1'b0;
        cmp_rdata = '0;

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // prio_q names the port that wins a tie; it flips away from every grant
                    g         = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
                    gnt_d     = g;
                    prio_d    = ~g;
                    pwrite_d  = g ? bus.req1_write : bus.req0_write;
                    paddr_d   = g ? bus.req1_addr  : bus.req0_addr;
                    pwdata_d  = g ? bus.req1_wdata : bus.req0_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    cmp       = 1'b1;
                    cmp_err   = bus.pslverr;
                    cmp_rdata = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
                end else if (wait_q == TO_LAST) begin
                    cmp     = 1'b1;
                    cmp_err = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmp) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            wait_d    = '0;
            state_d   = IDLE;
            if (gnt_q) begin
                done1_d  = 1'b1;
                err1_d   = cmp_err;
                rdata1_d = cmp_rdata;
            end else begin
                done0_d  = 1'b1;
                err0_d   = cmp_err;
                rdata0_d = cmp_rdata;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            gnt_q     <= 1'b0;
            wait_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            wait_q    <= wait_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.req0_done  = done0_q;
    assign bus.req0_rdata = rdata0_q;
    assign bus.req0_err   = err0_q;
    assign bus.req1_done  = done1_q;
    assign bus.req1_rdata = rdata1_q;
    assign bus.req1_err   = err1_q;
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter with a small APB register slave
// whose ready/error behaviour is steered by the stimulus.
module tb_apb_bus_arbiter;
    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    apb_bus_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    apb_bus_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.master)
    );

    always #5 pclk = ~pclk;

    // APB slave: 16 byte registers, optional wait states, optional hang
    logic [7:0] mem [16];
    int         stall_n = 0;
    logic       hang    = 1'b0;
    logic       slverr  = 1'b0;
    int         acc_cnt = 0;

    assign bus.prdata  = mem[bus.paddr];
    assign bus.pready  = !hang && (acc_cnt >= stall_n);
    assign bus.pslverr = slverr;

    always @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite)
            mem[bus.paddr] <= bus.pwdata;
    end

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    always @(negedge pclk)
        if (presetn && bus.penable && !bus.psel) viol++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [3:0] last_addr;
    logic [7:0] last_wdata;

    task automatic xfer(input int port, input logic wr, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int cyc,
                        output int nsel, output int nen);
        logic got;
        @(negedge pclk);
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end
        got = 1'b0; cyc = 0; nsel = 0; nen = 0; rd = '0; er = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge pclk); #1;
            cyc++;
            if (bus.psel)    nsel++;
            if (bus.penable) begin nen++; last_addr = bus.paddr; last_wdata = bus.pwdata; end
            if (port == 0 ? bus.req0_done : bus.req1_done) begin
                got = 1'b1;
                rd  = (port == 0) ? bus.req0_rdata : bus.req1_rdata;
                er  = (port == 0) ? bus.req0_err   : bus.req1_err;
            end
        end
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
        check("done_seen", 32'(got), 32'd1);
    endtask

    logic [7:0] rd;
    logic       er;
    int         cyc, nsel, nen;
    logic [7:0] exp_rb [4];
    int         order [$];

    initial begin
        exp_rb[0] = 8'hDE; exp_rb[1] = 8'hAD; exp_rb[2] = 8'hBE; exp_rb[3] = 8'hEF;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        check("rst_psel",    32'(bus.psel),      32'd0);
        check("rst_penable", 32'(bus.penable),   32'd0);
        check("rst_pwrite",  32'(bus.pwrite),    32'd0);
        check("rst_paddr",   32'(bus.paddr),     32'd0);
        check("rst_pwdata",  32'(bus.pwdata),    32'd0);
        check("rst_done",    32'({bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err}), 32'd0);
        check("rst_rdata",   32'({bus.req0_rdata, bus.req1_rdata}), 32'd0);
        @(negedge pclk) presetn = 1'b1;

        // single write, zero-wait
        xfer(0, 1'b1, 4'h0, 8'hDE, rd, er, cyc, nsel, nen);
        check("wr_cycles", 32'(cyc), 32'd3);
        check("wr_nsel",   32'(nsel), 32'd2);
        check("wr_nen",    32'(nen), 32'd1);
        check("wr_paddr",  32'(last_addr), 32'd0);
        check("wr_pwdata", 32'(last_wdata), 32'hDE);
        check("wr_err",    32'(er), 32'd0);
        check("wr_rdata",  32'(rd), 32'd0);
        @(posedge pclk); #1;
        check("wr_done_pulse", 32'(bus.req0_done), 32'd0);

        // remaining writes, then read-back on port 1
        xfer(0, 1'b1, 4'h1, 8'hAD, rd, er, cyc, nsel, nen);
        xfer(0, 1'b1, 4'h2, 8'hBE, rd, er, cyc, nsel, nen);
        xfer(0, 1'b1, 4'h3, 8'hEF, rd, er, cyc, nsel, nen);
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b0, 4'(i), 8'h00, rd, er, cyc, nsel, nen);
            check("rb_rdata",  32'(rd), 32'(exp_rb[i]));
            check("rb_err",    32'(er), 32'd0);
            check("rb_cycles", 32'(cyc), 32'd3);
        end

        // 3 wait states then slave error on a read
        stall_n = 3; slverr = 1'b1;
        xfer(1, 1'b0, 4'h2, 8'h00, rd, er, cyc, nsel, nen);
        check("ws_cycles", 32'(cyc), 32'd6);
        check("ws_err",    32'(er), 32'd1);
        check("ws_rdata",  32'(rd), 32'd0);
        stall_n = 0; slverr = 1'b0;

        // timeout after 15 wait cycles
        hang = 1'b1;
        xfer(0, 1'b0, 4'h3, 8'h00, rd, er, cyc, nsel, nen);
        check("to_cycles", 32'(cyc), 32'd17);
        check("to_err",    32'(er), 32'd1);
        check("to_rdata",  32'(rd), 32'd0);
        check("to_psel",   32'(bus.psel), 32'd0);
        hang = 1'b0;
        xfer(0, 1'b0, 4'h1, 8'h00, rd, er, cyc, nsel, nen);
        check("post_to_rdata",  32'(rd), 32'hAD);
        check("post_to_err",    32'(er), 32'd0);
        check("post_to_cycles", 32'(cyc), 32'd3);

        // contention from reset: grants alternate starting with port 0
        @(negedge pclk) presetn = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 4'h0;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 4'h1;
        @(negedge pclk) presetn = 1'b1;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(posedge pclk); #1;
            if (bus.req0_done) order.push_back(0);
            if (bus.req1_done) order.push_back(1);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            check("rr_order", 32'(order[i]), 32'(i % 2));

        // reset in the middle of ACCESS
        @(negedge pclk);
        hang = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 4'h5; bus.req0_wdata = 8'h55;
        repeat (3) @(posedge pclk);
        #2;
        check("pre_rst_penable", 32'(bus.penable), 32'd1);
        presetn = 1'b0;
        #1;
        check("mid_rst_psel",    32'(bus.psel), 32'd0);
        check("mid_rst_penable", 32'(bus.penable), 32'd0);
        check("mid_rst_done",    32'({bus.req0_done, bus.req1_done}), 32'd0);
        hang = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 4'h0;
        @(negedge pclk) presetn = 1'b1;
        order.delete();
        for (int c = 0; c < 40 && order.size() < 2; c++) begin
            @(posedge pclk); #1;
            if (bus.req0_done) begin order.push_back(0); bus.req0_valid = 1'b0; end
            if (bus.req1_done) begin order.push_back(1); bus.req1_valid = 1'b0; end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        check("post_rst_count", 32'(order.size()), 32'd2);
        if (order.size() >= 2) begin
            check("post_rst_first",  32'(order[0]), 32'd0);
            check("post_rst_second", 32'(order[1]), 32'd1);
        end
        check("post_rst_mem5", 32'(mem[5]), 32'h55);

        check("penable_wo_psel", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
